// File: rtl/mem_read_streamer_pkg.sv
// Shared definitions for the memory read streamer: FSM state encoding and
// the valid/ready stream convention (a word transfers when valid && ready).
package mem_read_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FIN    = 2'd2
    } state_t;

    // A stream beat is accepted on any rising edge where both are high.
    function automatic logic beat(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/mem_read_streamer.sv
// Reads COUNT consecutive words from a combinational-read memory starting at
// BASE_ADDR and presents them as a valid/ready stream with a last flag.
module mem_read_streamer
    import mem_read_streamer_pkg::*;
#(
    parameter int wordsize = 8,
    parameter int addrsize = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [addrsize-1:0] base_addr,
    input  logic [addrsize:0]   count,
    output logic [addrsize-1:0] mem_addr,
    input  logic [wordsize-1:0] mem_readdata,
    output logic [wordsize-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    localparam logic [addrsize:0]   REM_ZERO = '0;
    localparam logic [addrsize:0]   REM_ONE  = (addrsize+1)'(1);
    localparam logic [addrsize-1:0] PTR_ONE  = addrsize'(1);

    state_t              state;
    logic [addrsize-1:0] rd_ptr;
    logic [addrsize:0]   remaining;
    logic                load;

    assign mem_addr = rd_ptr;

    // The output register may be refilled when empty or being drained this cycle.
    assign load = (!out_valid || out_ready) && (remaining != REM_ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (count != REM_ZERO) begin
                            rd_ptr    <= base_addr;
                            remaining <= count;
                            state     <= STREAM;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                STREAM: begin
                    if (load) begin
                        out_data  <= mem_readdata;
                        out_valid <= 1'b1;
                        out_last  <= (remaining == REM_ONE);
                        rd_ptr    <= rd_ptr + PTR_ONE;
                        remaining <= remaining - REM_ONE;
                    end else if (beat(out_valid, out_ready) && remaining == REM_ZERO) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_streamer.sv
// Directed bench for mem_read_streamer: a scoreboard queue holds the expected
// words of each burst and is drained as the stream hands words over.
module tb_mem_read_streamer;
    import mem_read_streamer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] count;
    logic [3:0] mem_addr;
    logic [7:0] mem_readdata;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [7:0] mem [16];
    logic [8:0] sb [$];
    int         total  = 0;
    int         passed = 0;

    always #5 clk = ~clk;

    // Combinational-read memory; its write side is the bench preload.
    assign mem_readdata = mem[mem_addr];

    mem_read_streamer #(.wordsize(8), .addrsize(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .mem_addr(mem_addr), .mem_readdata(mem_readdata), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // mode 0: ready always high, 1: fixed 1,0,0,1,0,1 pattern, 2: random ready.
    task automatic run_burst(input logic [3:0] b, input logic [4:0] c, input int mode, input bit inject);
        logic [8:0] e;
        logic [5:0] pat = 6'b101001;
        logic       held_v = 1'b0;
        logic [7:0] held_d = '0;
        logic       held_l = 1'b0;
        bit         rdy;
        bit         seen_done = 0;
        int         first_valid = -1;
        int         words = 0;
        for (int i = 0; i < int'(c); i++)
            sb.push_back({mem[4'(int'(b) + i)], (i == int'(c) - 1)});
        @(negedge clk);
        start = 1'b1; base_addr = b; count = c;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) begin
                check("done_queue_empty", sb.size(), 0);
                check("fin_busy", busy, 1);
                check("fin_valid_low", out_valid, 0);
                if (mode == 0) check("done_cycle", cyc, (c == 0) ? 0 : int'(c) + 1);
                seen_done = 1;
                break;
            end
            if (out_valid && first_valid < 0) begin
                first_valid = cyc;
                check("first_latency", cyc, 1);
            end
            if (held_v) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held_d);
                check("stall_last", out_last, held_l);
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 6] : 1'($urandom_range(0, 1));
            out_ready = rdy;
            if (inject) begin
                start = (cyc == 2); base_addr = 4'd0; count = 5'd1;
            end
            if (out_valid && rdy) begin
                words++;
                check("word_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("data", out_data, e[8:1]);
                    check("last", out_last, e[0]);
                    $display("burst b=%0d c=%0d word %0d: data=%02h last=%0b", b, c, words, out_data, out_last);
                end
            end
            held_v = out_valid && !rdy;
            held_d = out_data;
            held_l = out_last;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", seen_done, 1);
        if (c == 0) check("zero_no_valid", first_valid, -1);
        check("word_total", words, c);
        if (seen_done) begin
            @(negedge clk);
            check("done_single_cycle", done, 0);
            check("idle_busy_low", busy, 0);
        end
        sb.delete();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        #1;
        check("rst_addr", mem_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        run_burst(4'd2, 5'd4, 0, 0);   // basic
        run_burst(4'd2, 5'd4, 1, 0);   // backpressure
        run_burst(4'd14, 5'd4, 0, 0);  // wrap 14,15,0,1
        run_burst(4'd3, 5'd0, 0, 0);   // zero length
        run_burst(4'd5, 5'd16, 2, 0);  // full length, random stalls
        run_burst(4'd2, 5'd4, 1, 1);   // start while busy is ignored

        // Reset in the middle of a burst.
        @(negedge clk);
        start = 1'b1; base_addr = 4'd3; count = 5'd6; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_addr", mem_addr, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_reset_no_done", done, 0);
        end
        mem[7] = 8'hA5;  // fresh content to prove the new burst reads its own base
        run_burst(4'd7, 5'd3, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
